// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the architectural NOP encoding,
// and the IF/ID register layout that the ID stage reuses.
package cpu_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  // Architectural NOP, used for IF/ID bubbles.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Sticks at all-ones once reached and never wraps.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear has priority; otherwise count up by one until all-ones.
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, drives instruction memory, and holds the IF/ID
// register. Priority on every edge is reset > redirect > stall > normal.
// A redirect replaces the in-flight fetch with a single bubble.
module fetch_stage #(
  parameter logic [cpu_pkg::XLEN-1:0]    RESET_PC  = 64'h0,
  parameter logic [cpu_pkg::INSTR_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int                          CNT_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [cpu_pkg::XLEN-1:0]      redirect_pc,
  output logic [cpu_pkg::XLEN-1:0]      imem_addr,
  input  logic [cpu_pkg::INSTR_W-1:0]   imem_instr,
  output logic [cpu_pkg::INSTR_W-1:0]   if_id_instr,
  output logic [cpu_pkg::XLEN-1:0]      if_id_pc,
  output logic                          if_id_valid,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              redirect_cnt
);

  import cpu_pkg::*;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] redirect_tgt;
  if_id_t          if_id;

  // Sequential next PC; wraps naturally modulo 2^64.
  assign pc_seq       = pc + 64'd4;
  // Redirect targets are forced word-aligned.
  assign redirect_tgt = redirect_pc & ~64'h3;

  assign imem_addr   = pc;
  assign if_id_instr = if_id.instr;
  assign if_id_pc    = if_id.pc;
  assign if_id_valid = if_id.valid;

  // PC and IF/ID register update. A stall holds everything, so an unknown
  // imem_instr is only ever captured on a normal edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc    <= RESET_PC;
      if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else if (redirect_valid) begin
      pc    <= redirect_tgt;
      if_id <= '{instr: NOP_INSTR, pc: '0, valid: 1'b0};
    end else if (!stall) begin
      pc    <= pc_seq;
      if_id <= '{instr: imem_instr, pc: pc, valid: 1'b1};
    end
  end

  // A stall that coincides with a redirect is not a held cycle, so it
  // is not counted.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall & ~redirect_valid),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect_valid),
    .count (redirect_cnt)
  );

endmodule
